// File: rtl/mmm_ctrl.sv
// mmm_ctrl: sequencer for a bit-serial Montgomery multiplier datapath.
module mmm_ctrl #(
  parameter int ITERS = 12,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          en,
  input  logic          start,
  input  logic          abort,
  input  logic          ge_i,
  output logic          rst_mmm_o,
  output logic          ld_a_o,
  output logic          step_o,
  output logic          sub_o,
  output logic [CW-1:0] cnt_o,
  output logic          busy_o,
  output logic          done_o
);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, CORR, DONE} state_t;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rst_mmm_q, rst_mmm_d;
  logic          kill;
  always_comb begin
    kill      = en && abort && busy_o;
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_mmm_d = rst_mmm_q;
    if (en) begin
      case (state_q)
        IDLE:    state_d = (start && !abort) ? CLEAR : IDLE;
        CLEAR:   state_d = LOAD;
        LOAD:    state_d = RUN;
        RUN:     state_d = (cnt_q == LAST) ? CORR : RUN;
        CORR:    state_d = DONE;
        default: state_d = IDLE;
      endcase
      if (kill) state_d = IDLE;
      cnt_d     = (state_q == RUN && state_d == RUN) ? cnt_q + 1'b1 : '0;
      // datapath clear is registered so it never glitches; also pulsed on abort
      rst_mmm_d = !(kill || state_d == CLEAR);
    end
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rst_mmm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_mmm_q <= rst_mmm_d;
    end
  end
  assign busy_o    = state_q inside {CLEAR, LOAD, RUN, CORR};
  assign ld_a_o    = state_q == LOAD;
  assign done_o    = state_q == DONE;
  assign step_o    = en && (state_q == LOAD || state_q == RUN);
  assign sub_o     = en && ge_i && state_q == CORR;
  assign cnt_o     = cnt_q;
  assign rst_mmm_o = rst_mmm_q;
endmodule

// File: tb/tb_mmm_ctrl.sv
// tb_mmm_ctrl: directed and randomized checks of mmm_ctrl against an operation-position model.
module tb_mmm_ctrl;
  localparam int IT = 12;
  logic clk = 1'b0, rstb = 1'b0, en = 1'b0, start = 1'b0, abort = 1'b0, ge_i = 1'b0;
  logic rst_mmm_o, ld_a_o, step_o, sub_o, busy_o, done_o;
  logic [3:0] cnt_o;
  int total = 0, bad = 0;
  int m_pos = 0;
  logic m_rst = 1'b0;

  mmm_ctrl #(.ITERS(IT), .CW(4)) dut (
    .clk(clk), .rstb(rstb), .en(en), .start(start), .abort(abort), .ge_i(ge_i),
    .rst_mmm_o(rst_mmm_o), .ld_a_o(ld_a_o), .step_o(step_o), .sub_o(sub_o),
    .cnt_o(cnt_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic e, input logic s, input logic a, input logic g);
    en = e; start = s; abort = a; ge_i = g;
    #2;
  endtask

  // model: m_pos is the position within an operation (0 idle, 1 clear .. IT+4 done)
  task automatic tick();
    @(posedge clk);
    if (!rstb) begin
      m_pos = 0; m_rst = 1'b0;
    end else if (en) begin
      if (m_pos == 0) begin
        m_pos = (start && !abort) ? 1 : 0;
        m_rst = (m_pos != 1);
      end else if (abort && m_pos <= IT + 3) begin
        m_pos = 0; m_rst = 1'b0;
      end else begin
        m_pos = (m_pos == IT + 4) ? 0 : m_pos + 1;
        m_rst = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 1);
    total++; if ({rst_mmm_o, ld_a_o, step_o, sub_o, busy_o, done_o} !== 6'b0) begin bad++; $display("FAIL reset_outs got=%b exp=000000", {rst_mmm_o, ld_a_o, step_o, sub_o, busy_o, done_o}); end
    total++; if (cnt_o !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt_o); end
    tick();
    drive(1, 0, 0, 0);
    rstb = 1'b1;
    tick();
    total++; if (rst_mmm_o !== 1'b1) begin bad++; $display("FAIL reset_release_rst got=%b exp=1", rst_mmm_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_normal(input logic g);
    int steps = 0, first_step = -1, subs = 0, sub_c = -1, dones = 0, done_c = -1, rlow = 0, rlow_c = -1, ld_c = -1;
    for (int c = 0; c < 26; c++) begin
      drive(1, c == 0, 0, g);
      if (step_o) begin steps++; if (first_step < 0) first_step = c; end
      if (sub_o) begin subs++; sub_c = c; end
      if (done_o) begin dones++; done_c = c; end
      if (!rst_mmm_o) begin rlow++; rlow_c = c; end
      if (ld_a_o && ld_c < 0) ld_c = c;
      tick();
    end
    total++; if (steps != 13 || first_step != 2) begin bad++; $display("FAIL normal_step count=%0d first=%0d exp=13,2", steps, first_step); end
    total++; if (dones != 1 || done_c != 16) begin bad++; $display("FAIL normal_done count=%0d cyc=%0d exp=1,16", dones, done_c); end
    total++; if (rlow != 1 || rlow_c != 1) begin bad++; $display("FAIL normal_rstmmm count=%0d cyc=%0d exp=1,1", rlow, rlow_c); end
    total++; if (ld_c != 2) begin bad++; $display("FAIL normal_ld cyc=%0d exp=2", ld_c); end
    if (g) begin
      total++; if (subs != 1 || sub_c != 15) begin bad++; $display("FAIL ge_sub count=%0d cyc=%0d exp=1,15", subs, sub_c); end
    end else begin
      total++; if (subs != 0) begin bad++; $display("FAIL nosub_sub count=%0d exp=0", subs); end
    end
  endtask

  task automatic test_stall();
    int stall = 0, done_c = -1;
    bit seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (!seen && busy_o && cnt_o == 4'd6) begin seen = 1; stall = 5; end
      drive(stall == 0, c == 0, 0, 1);
      if (stall > 0) begin
        total++; if (cnt_o !== 4'd6 || step_o !== 1'b0) begin bad++; $display("FAIL stall_hold cyc=%0d cnt=%0d step=%b exp=6,0", c, cnt_o, step_o); end
        stall--;
      end
      if (done_o && done_c < 0) done_c = c;
      tick();
    end
    total++; if (done_c != 21) begin bad++; $display("FAIL stall_done cyc=%0d exp=21", done_c); end
  endtask

  task automatic test_abort();
    int ab_c = -1, dones = 0;
    for (int c = 0; c < 25; c++) begin
      if (ab_c < 0 && busy_o && cnt_o == 4'd3) begin
        ab_c = c;
        drive(1, 0, 1, 0);
      end else drive(1, 0, 0, 0);
      if (c == 0) begin start = 1'b1; #1; end
      if (ab_c >= 0 && c == ab_c + 1) begin
        total++; if (busy_o !== 1'b0 || rst_mmm_o !== 1'b0 || cnt_o !== 4'd0) begin bad++; $display("FAIL abort_next busy=%b rst=%b cnt=%0d exp=0,0,0", busy_o, rst_mmm_o, cnt_o); end
      end
      if (ab_c >= 0 && c == ab_c + 2) begin
        total++; if (rst_mmm_o !== 1'b1) begin bad++; $display("FAIL abort_rst_back got=%b exp=1", rst_mmm_o); end
      end
      if (done_o) dones++;
      tick();
    end
    total++; if (ab_c != 6 || dones != 0) begin bad++; $display("FAIL abort_nodone abort_cyc=%0d dones=%0d exp=6,0", ab_c, dones); end
    test_normal(1'b0);
  endtask

  task automatic test_back_to_back();
    int dc[$];
    for (int c = 0; c < 60; c++) begin
      drive(1, c < 40, 0, 0);
      if (done_o) dc.push_back(c);
      tick();
    end
    total++; if (dc.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", dc.size()); end
    else begin
      total++; if (dc[0] != 16) begin bad++; $display("FAIL b2b_first got=%0d exp=16", dc[0]); end
      total++; if (dc[1] - dc[0] != 17 || dc[2] - dc[1] != 17) begin bad++; $display("FAIL b2b_spacing got=%0d,%0d exp=17,17", dc[1] - dc[0], dc[2] - dc[1]); end
    end
  endtask

  task automatic test_async_reset();
    int dones = 0;
    bit hit = 0;
    for (int c = 0; c < 30 && !hit; c++) begin
      drive(1, c == 0, 0, 1);
      if (busy_o && cnt_o == 4'd8) hit = 1; else tick();
    end
    total++; if (!hit) begin bad++; $display("FAIL areset_reach cnt=%0d exp=8", cnt_o); end
    rstb = 1'b0; m_pos = 0; m_rst = 1'b0;
    #1;
    total++; if ({rst_mmm_o, ld_a_o, step_o, sub_o, busy_o, done_o} !== 6'b0 || cnt_o !== 4'd0) begin bad++; $display("FAIL areset_outs got=%b cnt=%0d exp=000000,0", {rst_mmm_o, ld_a_o, step_o, sub_o, busy_o, done_o}, cnt_o); end
    tick();
    drive(1, 0, 0, 0);
    rstb = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      drive(1, 0, 0, 0);
      if (done_o || busy_o) dones++;
    end
    total++; if (dones != 0 || rst_mmm_o !== 1'b1) begin bad++; $display("FAIL areset_after active=%0d rst=%b exp=0,1", dones, rst_mmm_o); end
  endtask

  task automatic test_random();
    logic e, g;
    logic [3:0] ec;
    for (int c = 0; c < 800; c++) begin
      e = ($urandom_range(0, 9) != 0);
      g = $urandom_range(0, 1);
      drive(e, $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0, g);
      ec = (m_pos >= 3 && m_pos <= IT + 2) ? 4'(m_pos - 3) : 4'd0;
      total++; if (busy_o !== (m_pos >= 1 && m_pos <= IT + 3)) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b pos=%0d", c, busy_o, m_pos); end
      total++; if (done_o !== (m_pos == IT + 4)) begin bad++; $display("FAIL rnd_done cyc=%0d got=%b pos=%0d", c, done_o, m_pos); end
      total++; if (ld_a_o !== (m_pos == 2)) begin bad++; $display("FAIL rnd_ld cyc=%0d got=%b pos=%0d", c, ld_a_o, m_pos); end
      total++; if (step_o !== (e && m_pos >= 2 && m_pos <= IT + 2)) begin bad++; $display("FAIL rnd_step cyc=%0d got=%b pos=%0d en=%b", c, step_o, m_pos, e); end
      total++; if (sub_o !== (e && g && m_pos == IT + 3)) begin bad++; $display("FAIL rnd_sub cyc=%0d got=%b pos=%0d", c, sub_o, m_pos); end
      total++; if (cnt_o !== ec) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, cnt_o, ec); end
      total++; if (rst_mmm_o !== m_rst) begin bad++; $display("FAIL rnd_rstmmm cyc=%0d got=%b exp=%b", c, rst_mmm_o, m_rst); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_normal(1'b0);
    test_normal(1'b1);
    test_stall();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
